// File: rtl/mod_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_calc_pkg
//  Description : Shared types and elaboration-time helpers for the
//                residue-arithmetic modular blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mod_seq_state_t;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // (d * c * 2^(chunk_w*k)) mod m, reduced at every step so that no
    // intermediate product exceeds m*m.
    function automatic int mod_lut_entry(input int d, input int k, input int c,
                                         input int m, input int chunk_w);
        longint radix;
        longint scale;
        longint prod;
        radix = (longint'(1) << chunk_w) % longint'(m);
        scale = longint'(1) % longint'(m);
        for (int i = 0; i < k; i++) begin
            scale = (scale * radix) % longint'(m);
        end
        prod = ((longint'(d) % longint'(m)) * (longint'(c) % longint'(m))) % longint'(m);
        return int'((prod * scale) % longint'(m));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_const_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_const_mul_seq_if
//  Description : Operand/result valid-ready bundle of the sequential modular
//                constant multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_const_mul_seq_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_x;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_r;

    modport master (
        output in_valid, in_x, in_mode, out_ready,
        input  in_ready, out_valid, out_r
    );

    modport slave (
        input  in_valid, in_x, in_mode, out_ready,
        output in_ready, out_valid, out_r
    );
endinterface
`default_nettype wire

// File: rtl/mod_add.sv
`default_nettype none
// ============================================================================
//  Module      : mod_add
//  Description : Combinational modular adder, (a + b) mod MODULUS, for
//                operands already reduced below MODULUS.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_add #(
    parameter int MODULUS = 503,
    parameter int OUT_W   = 9
) (
    input  wire logic [OUT_W-1:0] i_a,
    input  wire logic [OUT_W-1:0] i_b,
    output logic      [OUT_W-1:0] o_sum
);
    localparam logic [OUT_W:0] c_MOD = (OUT_W+1)'(MODULUS);

    logic [OUT_W:0] w_raw;
    logic [OUT_W:0] w_sub;

    // Both inputs are below the modulus, so a single conditional subtract
    // brings the sum back into range.
    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = w_raw - c_MOD;
    assign o_sum = (w_raw >= c_MOD) ? w_sub[OUT_W-1:0] : w_raw[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_const_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_const_mul_seq
//  Description : Sequential r = (x * MUL_CONST) mod MODULUS, one CHUNK_W-bit
//                digit per cycle LSB-first through per-position constant tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_const_mul_seq
    import mod_calc_pkg::*;
#(
    parameter int MODULUS   = 503,
    parameter int MUL_CONST = 500,
    parameter int IN_W      = 18,
    parameter int CHUNK_W   = 6,
    parameter int OUT_W     = clog2(MODULUS)
) (
    input wire logic           clk,
    input wire logic           rst,
    mod_const_mul_seq_if.slave bus
);
    localparam int c_N_CHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int c_SHIFT_W = c_N_CHUNK * CHUNK_W;
    localparam int c_K_W     = (c_N_CHUNK > 1) ? clog2(c_N_CHUNK) : 1;
    localparam int c_DEPTH   = 1 << CHUNK_W;
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_N_CHUNK - 1);

    generate
        if (IN_W + 2 * OUT_W > 64 || MODULUS < 2 || MODULUS >= (1 << OUT_W) ||
            MUL_CONST < 0 || MUL_CONST >= MODULUS) begin : g_param_check
            $error("mod_const_mul_seq: unsupported parameter combination");
        end
    endgenerate

    mod_seq_state_t         r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_mode;
    logic [c_K_W-1:0]       r_k;
    logic [c_SHIFT_W-1:0]   r_shift;
    logic [OUT_W-1:0]       r_acc;
    logic [OUT_W-1:0]       w_entry;
    logic [OUT_W-1:0]       w_sum;
    logic [OUT_W-1:0]       w_tab [2][c_N_CHUNK][c_DEPTH];

    // Mode 1 is plain reduction: the same tables with the constant set to 1.
    generate
        for (genvar m = 0; m < 2; m++) begin : g_tab_mode
            for (genvar k = 0; k < c_N_CHUNK; k++) begin : g_tab_pos
                for (genvar d = 0; d < c_DEPTH; d++) begin : g_tab_digit
                    localparam int c_ENTRY = mod_lut_entry(d, k, (m == 0) ? MUL_CONST : 1,
                                                           MODULUS, CHUNK_W);
                    assign w_tab[m][k][d] = OUT_W'(c_ENTRY);
                end
            end
        end
    endgenerate

    assign w_entry = w_tab[r_mode][r_k][r_shift[CHUNK_W-1:0]];

    mod_add #(
        .MODULUS (MODULUS),
        .OUT_W   (OUT_W)
    ) u_mod_add (
        .i_a   (r_acc),
        .i_b   (w_entry),
        .o_sum (w_sum)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mode      <= 1'b0;
            r_k         <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_shift    <= c_SHIFT_W'(bus.in_x);
                        r_mode     <= bus.in_mode;
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_sum;
                    r_k     <= r_k + 1'b1;
                    r_shift <= r_shift >> CHUNK_W;
                    if (r_k == c_K_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_const_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_const_mul_seq
//  Description : Self-checking bench for mod_const_mul_seq (default and
//                MODULUS=257 / MUL_CONST=3 / IN_W=20 / CHUNK_W=4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_const_mul_seq;

    localparam int M0 = 503, C0 = 500, IW0 = 18, CW0 = 6, OW0 = 9;
    localparam int M1 = 257, C1 = 3,   IW1 = 20, CW1 = 4, OW1 = 9;
    localparam int NCH0    = (IW0 + CW0 - 1) / CW0;
    localparam int N_RAND0 = 6000;
    localparam int N_RAND1 = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rnd0_en  = 1'b0;
    bit   rnd1_en  = 1'b0;
    bit   alt_done = 1'b0;
    int   got0     = 0;
    int   got1     = 0;
    longint q0[$];
    longint q1[$];

    mod_const_mul_seq_if #(.IN_W(IW0), .OUT_W(OW0)) bus0 ();
    mod_const_mul_seq_if #(.IN_W(IW1), .OUT_W(OW1)) bus1 ();

    mod_const_mul_seq #(
        .MODULUS (M0), .MUL_CONST (C0), .IN_W (IW0), .CHUNK_W (CW0), .OUT_W (OW0)
    ) u_dut0 (
        .clk (clk), .rst (rst0), .bus (bus0)
    );

    mod_const_mul_seq #(
        .MODULUS (M1), .MUL_CONST (C1), .IN_W (IW1), .CHUNK_W (CW1), .OUT_W (OW1)
    ) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the arithmetic definition of the result.
    function automatic longint ref_mul(input longint x, input bit mode,
                                       input longint c, input longint m);
        return mode ? (x % m) : ((x * c) % m);
    endfunction

    function automatic longint pick_x(input int iw, input int m);
        longint all_ones;
        all_ones = (longint'(1) << iw) - 1;
        case ($urandom % 8)
            0:       return 0;
            1:       return all_ones;
            2:       return longint'($urandom_range(0, int'(all_ones / m))) * m;
            default: return longint'($urandom) & all_ones;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready0;
        int n;
        n = 0;
        while (!bus0.in_ready && n < 50) begin
            tick;
            n++;
        end
        chk("in_ready_wait0", bus0.in_ready, 1);
    endtask

    // One operand through the default instance; 'hold' cycles of
    // backpressure with stray in_valid pulses before the result is taken.
    task automatic run_op0(input longint x, input bit mode, input string tag, input int hold);
        longint exp;
        int     lat;
        exp = ref_mul(x, mode, C0, M0);
        wait_ready0;
        bus0.in_valid = 1'b1;
        bus0.in_x     = IW0'(x);
        bus0.in_mode  = mode;
        tick;
        bus0.in_valid = 1'b0;
        bus0.in_x     = IW0'($urandom);
        bus0.in_mode  = ~mode;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            chk({tag, "_busy_rdy"}, bus0.in_ready, 0);
            tick;
            lat++;
        end
        chk({tag, "_latency"}, lat, NCH0);
        chk({tag, "_r"}, bus0.out_r, exp);
        chk({tag, "_done_rdy"}, bus0.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus0.in_valid = $urandom_range(0, 1);
            bus0.in_x     = IW0'($urandom);
            tick;
            chk({tag, "_hold_r"}, bus0.out_r, exp);
            chk({tag, "_hold_valid"}, bus0.out_valid, 1);
            chk({tag, "_hold_rdy"}, bus0.in_ready, 0);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        tick;
        bus0.out_ready = 1'b0;
        chk({tag, "_post_valid"}, bus0.out_valid, 0);
        chk({tag, "_post_rdy"}, bus0.in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rnd0_en && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) chk("rnd0_spurious", bus0.out_r, -1);
            else                chk("rnd0_r", bus0.out_r, q0.pop_front());
            got0++;
        end
        if (rnd1_en && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) chk("rnd1_spurious", bus1.out_r, -1);
            else                chk("rnd1_r", bus1.out_r, q1.pop_front());
            got1++;
        end
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Second configuration: fully randomised traffic.
    initial begin
        bus1.in_valid  = 1'b0;
        bus1.in_x      = '0;
        bus1.in_mode   = 1'b0;
        bus1.out_ready = 1'b0;
        rst1 = 1'b1;
        repeat (3) tick;
        rst1 = 1'b0;
        chk("alt_reset_rdy", bus1.in_ready, 1);
        chk("alt_reset_valid", bus1.out_valid, 0);
        chk("alt_reset_r", bus1.out_r, 0);
        rnd1_en = 1'b1;
        fork
            begin : p_prod1
                for (int i = 0; i < N_RAND1; i++) begin
                    longint x;
                    bit     mode;
                    int     n;
                    repeat ($urandom_range(0, 1)) tick;
                    x    = pick_x(IW1, M1);
                    mode = 1'($urandom % 2);
                    bus1.in_valid = 1'b1;
                    bus1.in_x     = IW1'(x);
                    bus1.in_mode  = mode;
                    n = 0;
                    while (!bus1.in_ready && n < 50) begin
                        tick;
                        n++;
                    end
                    chk("in_ready_wait1", bus1.in_ready, 1);
                    q1.push_back(ref_mul(x, mode, C1, M1));
                    tick;
                    bus1.in_valid = 1'b0;
                    bus1.in_x     = IW1'($urandom);
                end
            end
            begin : p_cons1
                int g;
                g = 0;
                while (got1 < N_RAND1 && g < 100000) begin
                    bus1.out_ready = ($urandom % 4) != 0;
                    tick;
                    g++;
                end
                bus1.out_ready = 1'b0;
            end
        join
        chk("alt_count", got1, N_RAND1);
        chk("alt_leftover", q1.size(), 0);
        alt_done = 1'b1;
    end

    initial begin
        int w;
        bus0.in_valid  = 1'b0;
        bus0.in_x      = '0;
        bus0.in_mode   = 1'b0;
        bus0.out_ready = 1'b0;
        rst0 = 1'b1;
        repeat (3) tick;
        rst0 = 1'b0;
        chk("reset_rdy", bus0.in_ready, 1);
        chk("reset_valid", bus0.out_valid, 0);
        chk("reset_r", bus0.out_r, 0);

        run_op0(1,      1'b0, "x1",        0);
        run_op0(2,      1'b0, "x2",        0);
        run_op0(0,      1'b0, "x0",        0);
        run_op0(503,    1'b0, "x503",      0);
        run_op0(63,     1'b0, "x63",       0);
        run_op0(262143, 1'b0, "xones",     0);
        run_op0(262143, 1'b1, "m1_ones",   0);
        run_op0(502,    1'b1, "m1_502",    0);
        run_op0(1006,   1'b1, "m1_1006",   0);
        run_op0(262143, 1'b0, "backpress", 10);
        run_op0(2,      1'b0, "after_bp",  0);

        // Abort after one digit has been accumulated.
        wait_ready0;
        bus0.in_valid = 1'b1;
        bus0.in_x     = IW0'(5);
        bus0.in_mode  = 1'b0;
        tick;
        bus0.in_valid = 1'b0;
        tick;
        rst0 = 1'b1;
        tick;
        rst0 = 1'b0;
        chk("abort_valid", bus0.out_valid, 0);
        chk("abort_rdy", bus0.in_ready, 1);
        chk("abort_r", bus0.out_r, 0);
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_quiet", bus0.out_valid, 0);
        end
        bus0.out_ready = 1'b0;
        run_op0(1, 1'b0, "after_abort", 0);

        rnd0_en = 1'b1;
        fork
            begin : p_prod0
                for (int i = 0; i < N_RAND0; i++) begin
                    longint x;
                    bit     mode;
                    repeat ($urandom_range(0, 1)) tick;
                    x    = pick_x(IW0, M0);
                    mode = 1'($urandom % 2);
                    bus0.in_valid = 1'b1;
                    bus0.in_x     = IW0'(x);
                    bus0.in_mode  = mode;
                    wait_ready0;
                    q0.push_back(ref_mul(x, mode, C0, M0));
                    tick;
                    bus0.in_valid = 1'b0;
                    bus0.in_x     = IW0'($urandom);
                end
            end
            begin : p_cons0
                int g;
                g = 0;
                while (got0 < N_RAND0 && g < 100000) begin
                    bus0.out_ready = ($urandom % 4) != 0;
                    tick;
                    g++;
                end
                bus0.out_ready = 1'b0;
            end
        join
        chk("rnd0_count", got0, N_RAND0);
        chk("rnd0_leftover", q0.size(), 0);

        w = 0;
        while (!alt_done && w < 100000) begin
            tick;
            w++;
        end
        chk("alt_done", alt_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
